// File: rtl/score_pkg.sv
// Shared encodings, limits and the BCD increment helper for the Dino score path.
package score_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } state_t;

  localparam logic [3:0]  BCD_DIGIT_MAX = 4'h9;
  localparam logic [15:0] SCORE_MAX     = 16'h9999;

  // Ripple a +1 through four BCD digits; each digit wraps 9->0 and carries.
  function automatic logic [15:0] bcd4_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] >= BCD_DIGIT_MAX) begin
          r[i*4 +: 4] = 4'h0;
          carry       = 1'b1;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'h1;
          carry       = 1'b0;
        end
      end else begin
        r[i*4 +: 4] = v[i*4 +: 4];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd4_counter.sv
// Four-digit BCD score register with clear, saturating increment and hundreds carry.
module bcd4_counter
  import score_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] value,
  output logic        hundred_carry,
  output logic        at_max
);

  logic [15:0] value_r;

  assign value         = value_r;
  assign at_max        = (value_r == SCORE_MAX);
  // Asserted in the cycle whose closing edge moves the count from xx99 to xy00.
  assign hundred_carry = inc & ~at_max & (value_r[7:0] == 8'h99);

  // Score register: clear dominates, increment stops at 9999.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_r <= 16'h0000;
    end else if (clr) begin
      value_r <= 16'h0000;
    end else if (inc && !at_max) begin
      value_r <= bcd4_inc(value_r);
    end else begin
      value_r <= value_r;
    end
  end

endmodule

// File: rtl/score_sequencer.sv
// Run controller: IDLE/RUN/OVER FSM, tick prescaler, high-score register and speed level.
module score_sequencer
  import score_pkg::*;
#(
  parameter int TICK_CYCLES = 33554432,
  parameter int LEVEL_MAX   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        collide,
  input  logic        pause,
  output logic [31:0] data,
  output logic [1:0]  state,
  output logic        tick,
  output logic [2:0]  level,
  output logic        game_over
);

  localparam int            PW        = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] TERM      = PW'(TICK_CYCLES - 1);
  localparam logic [2:0]    LEVEL_TOP = 3'(LEVEL_MAX);

  state_t        state_r, state_nxt_s;
  logic [PW-1:0] presc_r, presc_nxt_s;
  logic [15:0]   hi_r, hi_nxt_s;
  logic [2:0]    level_r;
  logic          tick_r, tick_nxt_s;
  logic          game_over_r;
  logic          clr_s, inc_s;
  logic [15:0]   score_s;
  logic          hundred_carry_s, at_max_s;

  bcd4_counter u_score (
    .clk           (clk),
    .rst           (rst),
    .clr           (clr_s),
    .inc           (inc_s),
    .value         (score_s),
    .hundred_carry (hundred_carry_s),
    .at_max        (at_max_s)
  );

  // Next-state, prescaler, high-score and counter-control decode.
  always_comb begin
    state_nxt_s = state_r;
    presc_nxt_s = presc_r;
    hi_nxt_s    = hi_r;
    tick_nxt_s  = 1'b0;
    clr_s       = 1'b0;
    inc_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        clr_s       = 1'b1;
        presc_nxt_s = '0;
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (collide) begin
          // Collision beats a coincident terminal count: no increment, prescaler restarts.
          state_nxt_s = ST_OVER;
          presc_nxt_s = '0;
          if (score_s > hi_r) begin
            hi_nxt_s = score_s;
          end else begin
            hi_nxt_s = hi_r;
          end
        end else if (pause) begin
          presc_nxt_s = presc_r;
        end else if (presc_r == TERM) begin
          presc_nxt_s = '0;
          if (!at_max_s) begin
            inc_s      = 1'b1;
            tick_nxt_s = 1'b1;
          end else begin
            inc_s      = 1'b0;
            tick_nxt_s = 1'b0;
          end
        end else begin
          presc_nxt_s = presc_r + {{(PW-1){1'b0}}, 1'b1};
        end
      end
      ST_OVER: begin
        if (start) begin
          state_nxt_s = ST_RUN;
          clr_s       = 1'b1;
          presc_nxt_s = '0;
        end else begin
          state_nxt_s = ST_OVER;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        clr_s       = 1'b1;
        presc_nxt_s = '0;
      end
    endcase
  end

  // FSM, prescaler, high score and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      presc_r     <= '0;
      hi_r        <= 16'h0000;
      tick_r      <= 1'b0;
      game_over_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      presc_r     <= presc_nxt_s;
      hi_r        <= hi_nxt_s;
      tick_r      <= tick_nxt_s;
      game_over_r <= (state_nxt_s == ST_OVER);
    end
  end

  // Speed level follows the hundreds carry of the score and saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_r <= 3'd0;
    end else if (clr_s) begin
      level_r <= 3'd0;
    end else if (hundred_carry_s && (level_r < LEVEL_TOP)) begin
      level_r <= level_r + 3'd1;
    end else begin
      level_r <= level_r;
    end
  end

  assign data      = {hi_r, score_s};
  assign state     = state_r;
  assign tick      = tick_r;
  assign level     = level_r;
  assign game_over = game_over_r;

endmodule

// File: tb/tb_score_sequencer.sv
// Self-checking bench for score_sequencer: vector table, directed corners and random run vs. model.
module tb_score_sequencer;

  localparam int TC = 4;

  logic        clk;
  logic        rst, start, collide, pause;
  logic [31:0] data;
  logic [1:0]  state;
  logic        tick;
  logic [2:0]  level;
  logic        game_over;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model in plain integers
  int m_st = 0;
  int m_sc = 0;
  int m_hi = 0;
  int m_pc = 0;
  bit m_tk = 1'b0;

  typedef struct {
    logic        r, s, c, p;
    logic [1:0]  st;
    logic        tk;
    logic [15:0] sc;
  } vec_t;

  vec_t tbl[14];

  score_sequencer #(.TICK_CYCLES(TC), .LEVEL_MAX(7)) dut (
    .clk(clk), .rst(rst), .start(start), .collide(collide), .pause(pause),
    .data(data), .state(state), .tick(tick), .level(level), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [2:0] exp_level(input int sc);
    return (sc / 100 > 7) ? 3'd7 : 3'(sc / 100);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_step(input bit r, input bit s, input bit c, input bit p);
    m_tk = 1'b0;
    if (r) begin
      m_st = 0; m_sc = 0; m_hi = 0; m_pc = 0;
    end else if (m_st == 0) begin
      m_sc = 0; m_pc = 0;
      if (s) m_st = 1;
    end else if (m_st == 1) begin
      if (c) begin
        if (m_sc > m_hi) m_hi = m_sc;
        m_st = 2; m_pc = 0;
      end else if (!p) begin
        if (m_pc == TC - 1) begin
          m_pc = 0;
          if (m_sc < 9999) begin m_sc++; m_tk = 1'b1; end
        end else m_pc++;
      end
    end else begin
      if (s) begin m_st = 1; m_sc = 0; m_pc = 0; end
    end
  endtask

  task automatic cyc(input bit s, input bit c, input bit p, input bit r);
    start = s; collide = c; pause = p; rst = r;
    @(posedge clk);
    model_step(r, s, c, p);
    #1;
    chk("state", 32'(state), 32'(m_st));
    chk("tick", 32'(tick), 32'(m_tk));
    chk("data", data, {to_bcd(m_hi), to_bcd(m_sc)});
    chk("level", 32'(level), 32'(exp_level(m_sc)));
    chk("game_over", 32'(game_over), 32'(m_st == 2));
    start = 1'b0; collide = 1'b0; pause = 1'b0; rst = 1'b0;
  endtask

  task automatic run_until(input int target, input int bound);
    for (int i = 0; i < bound && m_sc != target; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reach_score", 32'(data[15:0]), 32'(to_bcd(target)));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; collide = 1'b0; pause = 1'b0;

    //           r     s     c     p     st     tk    sc
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 16'h0000};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 16'h0000};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 16'h0000};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 16'h0000};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 16'h0001};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 16'h0001};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 16'h0001};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 16'h0001};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 16'h0001};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 16'h0002};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 16'h0002};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 16'h0002};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 16'h0000};

    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].s, tbl[i].c, tbl[i].p, tbl[i].r);
      chk("tbl_state", 32'(state), 32'(tbl[i].st));
      chk("tbl_tick", 32'(tick), 32'(tbl[i].tk));
      chk("tbl_score", 32'(data[15:0]), 32'(tbl[i].sc));
    end

    // Fresh run: 40 cycles reach 0010 via 0009
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 35) chk("score_0009", 32'(data[15:0]), 32'h0009);
    end
    chk("score_0010", 32'(data[15:0]), 32'h0010);
    chk("run_state", 32'(state), 32'h1);

    run_until(400, 2000);
    chk("level_4", 32'(level), 32'd4);
    run_until(9999, 45000);
    chk("level_sat", 32'(level), 32'd7);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("score_sat", 32'(data[15:0]), 32'h9999);
    chk("tick_sat", 32'(tick), 32'd0);

    // Collide coincident with a terminal count
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    run_until(23, 200);
    for (int i = 0; i < TC - 1; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("over_data", data, 32'h0023_0023);
    chk("over_state", 32'(state), 32'h2);
    chk("over_flag", 32'(game_over), 32'h1);
    chk("over_tick", 32'(tick), 32'h0);

    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    run_until(15, 200);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("hi_kept", 32'(data[31:16]), 32'h0023);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    run_until(31, 300);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("hi_new", 32'(data[31:16]), 32'h0031);

    // Pause with prescaler mid-count
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    run_until(7, 100);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("pause_tick", 32'(tick), 32'h0);
    end
    chk("pause_score", 32'(data[15:0]), 32'h0007);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("resume_wait", 32'(tick), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("resume_tick", 32'(tick), 32'h1);
    chk("resume_score", 32'(data[15:0]), 32'h0008);

    // Reset mid-run
    run_until(42, 200);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_data", data, 32'h0);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_level", 32'(level), 32'h0);

    // Restart without reset keeps high score
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    run_until(5, 100);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart_hi", 32'(data[31:16]), 32'h0005);
    chk("restart_score", 32'(data[15:0]), 32'h0000);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 20) == 0, ($urandom % 40) == 0, ($urandom % 4) == 0, ($urandom % 500) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/score_sequencer.md
Name: score_sequencer

Overview:
- Run controller for the Dino score datapath: FSM (IDLE/RUN/OVER) that decides when the score advances, and when it clears, freezes and commits.
- Owns a programmable tick prescaler, a 4-digit BCD current-score counter, a 4-digit BCD high-score register and a speed level for the obstacle generator.
- Drives the 32-bit packed BCD word consumed by the 7-segment display driver: high score in [31:16], current score in [15:0].

Parameters:
- TICK_CYCLES, 33554432, clk cycles per score increment (sim benches use 4); legal range 2..2^26.
- LEVEL_MAX, 7, saturation value of level.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse: begin or restart a run
- collide  input  1  one-cycle pulse from collision detect: end the run
- pause  input  1  level; while high in RUN, prescaler and score hold
- data  output  32  {hi_score[15:0], score[15:0]}, packed BCD, digit 0 in [3:0]
- state  output  2  00 IDLE, 01 RUN, 10 OVER (11 unused)
- tick  output  1  one-cycle pulse on each accepted score increment
- level  output  3  speed level, +1 per 100 points, saturates at LEVEL_MAX
- game_over  output  1  high while state==OVER

Behaviour:
- Reset (synchronous, rst high at clk edge) overrides everything from any state, including mid-run:
  - state=IDLE; data=32'h0; level=0; tick=0; prescaler=0.
- All outputs are registered.
- IDLE:
  - score, prescaler and level hold 0.
  - start -> RUN; collide and pause are ignored.
- RUN:
  - If pause=0, the prescaler counts 0..TICK_CYCLES-1.
  - At terminal count the prescaler wraps to 0 and a tick is accepted.
  - Accepted tick, on the same edge: tick=1 for one cycle, and score increments by 1 in BCD.
    - Each digit wraps 9->0 and carries into the next digit.
    - No digit ever holds A-F.
  - Score saturates at 9999: further terminal counts neither change the score nor assert tick.
  - Level increments on the edge where score goes from xx99 to xy00, saturating at LEVEL_MAX.
  - pause=1: prescaler, score, level and tick are frozen (tick=0). start is ignored.
  - collide=1 (regardless of pause) -> OVER on the next edge. It wins over a simultaneous terminal count: no increment, no tick, and the prescaler resets to 0.
  - start=1 in RUN (without collide) is ignored.
- Entering OVER, on the same edge as the RUN->OVER transition:
  - If score > hi_score, then hi_score <= score.
  - Magnitude compare is performed directly on the 16-bit packed BCD values, which is valid because the digits are always legal.
  - The new hi_score is visible the cycle after collide.
- OVER:
  - score, level and hi_score are frozen; game_over=1.
  - start -> RUN with score=0, level=0, prescaler=0; hi_score retained.
  - collide is ignored.
- start and collide in the same cycle in IDLE: go to RUN. The collide is ignored because it is only sampled in RUN.
- Latency:
  - start to first tick = TICK_CYCLES cycles with pause low (first increment on the TICK_CYCLES-th edge after entering RUN).
  - collide to state=OVER = 1 cycle.

Decomposition:
- Shared package score_pkg:
  - state encodings ST_IDLE=2'b00, ST_RUN=2'b01, ST_OVER=2'b10;
  - BCD_DIGIT_MAX=4'h9; SCORE_MAX=16'h9999.
- One natural sub-module: bcd4_counter. It is a 4-digit BCD incrementer register with:
  - inputs clr and inc;
  - outputs value[15:0], hundred_carry (one-cycle pulse on xx99->xy00) and at_max (value==9999).
- score_sequencer instantiates one bcd4_counter and itself holds the FSM, prescaler, hi_score register, compare logic and level counter.

Test Plan (TICK_CYCLES=4, LEVEL_MAX=7):
- Reset, then start pulse, then 40 cycles pause=0 -> tick every 4th cycle; data[15:0] reaches 16'h0010 with digits stepping 0009->0010; state=01.
- Preload via 400 ticks (1600 cycles) -> score 16'h0400 and level=4. Continue to 16'h9999 -> level stays 7. Further cycles -> score stays 9999 and tick stays 0.
- Run to 0023, pulse collide on the same cycle as a terminal count -> next cycle state=10, score 0023 (no increment), data[31:16]=0023, game_over=1.
- From OVER: start, run to 0015, collide -> hi stays 0023. Restart, run to 0031, collide -> hi=0031.
- In RUN at score 0007, hold pause high for 20 cycles -> score 0007 and tick=0 throughout. Release -> next tick resumes from the held prescaler value.
- Assert rst mid-RUN with score 0042 and hi 0031 -> next cycle data=32'h0, state=00, level=0. A start pulse alone, with no reset, never clears the high score.
